// File: rtl/ma_pkg.sv
// Shared moving-average constants and the averaging/rounding helper.
package ma_pkg;

    localparam int unsigned MA_DATA_W      = 32;
    localparam int unsigned MA_LOG2_WINDOW = 3;

    // Widest supported sample plus one headroom bit for the rounding add.
    localparam int unsigned MA_MAX_W = 64;
    localparam int unsigned MA_EXT_W = MA_MAX_W + 1;

    // Divide a sign-extended running sum by 2^log2_window, rounding half up.
    function automatic logic signed [MA_EXT_W-1:0] ma_round_shift(
        input logic signed [MA_EXT_W-1:0] sum,
        input int unsigned                log2_window
    );
        logic signed [MA_EXT_W-1:0] half;
        half = MA_EXT_W'(1) << (log2_window - 1);
        return (sum + half) >>> log2_window;
    endfunction

endpackage

// File: rtl/ma_output_decimator_if.sv
// Sample-in / average-out bundle of the decimator, with status flags.
interface ma_output_decimator_if
    import ma_pkg::*;
#(
    parameter int unsigned DATA_W = MA_DATA_W
);

    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     primed;
    logic                     overflow;

    // Decimator side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, primed, overflow
    );

    // Filter / consumer side.
    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, primed, overflow
    );

endinterface

// File: rtl/ma_sync_fifo.sv
// Generic synchronous FIFO; caller guarantees no push when full without a pop
// and no pop when empty.
module ma_sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;

    assign rdata = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers, count and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage; cleared so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ma_output_decimator.sv
// Moving-average output stage: drops warm-up sums, scales to an average,
// decimates, and buffers results behind a valid/ready port.
module ma_output_decimator
    import ma_pkg::*;
#(
    parameter int unsigned DATA_W      = MA_DATA_W,
    parameter int unsigned LOG2_WINDOW = MA_LOG2_WINDOW,
    parameter int unsigned DECIM       = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    ma_output_decimator_if.slave bus
);

    localparam int unsigned WINDOW = 2 ** LOG2_WINDOW;
    localparam int unsigned WARM_W = LOG2_WINDOW;
    localparam int unsigned PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [WARM_W-1:0]        warm_cnt;
    logic                     primed_q;
    logic [PH_W-1:0]          phase;
    logic                     take;
    logic signed [DATA_W-1:0] scaled;
    logic signed [DATA_W-1:0] s1_data;
    logic                     s1_keep;
    logic                     overflow_q;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DATA_W-1:0]        fifo_rdata;
    logic [CNT_W-1:0]         fifo_count;

    assign take   = bus.in_valid && primed_q;
    assign scaled = DATA_W'(ma_round_shift(MA_EXT_W'(bus.in_data), LOG2_WINDOW));

    // Warm-up: swallow the first WINDOW valid sums, then hold primed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_cnt <= '0;
            primed_q <= 1'b0;
        end else if (bus.in_valid && !primed_q) begin
            if (warm_cnt == WARM_W'(WINDOW - 1)) begin
                primed_q <= 1'b1;
            end else begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end
        end
    end

    // Decimation phase, advanced by every post-warm-up sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (take) begin
            phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
        end
    end

    // Stage 1: scaled sample and keep flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_data <= '0;
            s1_keep <= 1'b0;
        end else begin
            s1_keep <= take && (phase == '0);
            if (take) begin
                s1_data <= scaled;
            end
        end
    end

    // Stage 2: a same-edge pop frees a slot even when full.
    assign fifo_pop  = !fifo_empty && bus.out_ready;
    assign fifo_push = s1_keep && (!fifo_full || fifo_pop);

    ma_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (s1_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky drop flag: a kept sample met a full FIFO with no pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (s1_keep && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.out_data  = fifo_rdata;
    assign bus.out_valid = !fifo_empty;
    assign bus.primed    = primed_q;
    assign bus.overflow  = overflow_q;

    // Occupancy can never exceed the FIFO depth.
    assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_ma_output_decimator.sv
// Scoreboard bench: an arithmetic reference model predicts every output;
// a negedge monitor checks flags each cycle and data on every handshake.
module tb_ma_output_decimator;
    import ma_pkg::*;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned LOG2_WINDOW = 3;
    localparam int unsigned DECIM       = 4;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int          W           = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ma_output_decimator_if #(.DATA_W(DATA_W)) bus ();

    ma_output_decimator #(
        .DATA_W      (DATA_W),
        .LOG2_WINDOW (LOG2_WINDOW),
        .DECIM       (DECIM),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference-model state.
    int n_valid   = 0;
    bit pend_keep = 1'b0;
    int pend_val  = 0;
    int occ       = 0;
    bit ovf_m     = 1'b0;
    int exp_q[$];
    int got_q[$];

    int r2[3] = '{10, 10, 10};
    int r3[6] = '{2, 1, 1, -1, -2, 0};
    int v3[6] = '{12, 11, 4, -12, -13, -4};
    int r6[5] = '{1, 2, 3, 4, 5};
    int r5[4] = '{1, 2, 3, 4};

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Average of a running sum over W samples, rounded half up (floor of x/W + 1/2).
    function automatic int round_ref(input int x);
        longint v;
        longint q;
        v = longint'(x) + longint'(W / 2);
        q = v / W;
        if ((v % W) != 0 && v < 0) q = q - 1;
        return int'(q);
    endfunction

    // Model: keep the first post-warm-up sample and every DECIM-th after it;
    // a kept sample enters the FIFO one edge after being sampled.
    always @(posedge clk) begin
        bit pop_m;
        if (!rst_n) begin
            n_valid   = 0;
            pend_keep = 1'b0;
            occ       = 0;
            ovf_m     = 1'b0;
            exp_q.delete();
        end else begin
            pop_m = (occ > 0) && bus.out_ready;
            if (pend_keep) begin
                if (occ < int'(FIFO_DEPTH) || pop_m) begin
                    exp_q.push_back(pend_val);
                    occ++;
                end else begin
                    ovf_m = 1'b1;
                end
            end
            if (pop_m) occ--;
            pend_keep = 1'b0;
            if (bus.in_valid) begin
                n_valid++;
                if (n_valid > W && ((n_valid - W - 1) % int'(DECIM)) == 0) begin
                    pend_keep = 1'b1;
                    pend_val  = round_ref(bus.in_data);
                end
            end
        end
    end

    // Monitor: flags every cycle, data on each handshake, stability while stalled.
    bit stall_prev = 1'b0;
    int last_data  = 0;
    always @(negedge clk) begin
        chk("out_valid", bus.out_valid, occ > 0);
        chk("primed", bus.primed, n_valid >= W);
        chk("overflow", bus.overflow, ovf_m);
        if (stall_prev && bus.out_valid) chk("stall_stable", bus.out_data, last_data);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0d expected none at %0t", bus.out_data, $time);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
            got_q.push_back(bus.out_data);
        end
        stall_prev = rst_n && bus.out_valid && !bus.out_ready;
        last_data  = bus.out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Pad with random non-kept samples until the next sample is kept.
    task automatic align_kept();
        for (int g = 0; g < W + int'(DECIM) + 2; g++) begin
            if (n_valid >= W && ((n_valid - W) % int'(DECIM)) == 0) break;
            send(int'($urandom));
        end
    endtask

    task automatic send_kept(input int v);
        align_kept();
        send(v);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (occ == 0 && !pend_keep) break;
            tick();
        end
        tick();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_leftover", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_primed", bus.primed, 0);
        chk("rst_overflow", bus.overflow, 0);
        rst_n = 1'b1;

        // Warm-up: eight sums of 80 produce nothing.
        for (int i = 0; i < W; i++) begin
            chk("warm_primed", bus.primed, 0);
            send(80);
        end
        chk("primed_after", bus.primed, 1);
        chk("warm_no_valid", bus.out_valid, 0);
        chk("warm_overflow", bus.overflow, 0);

        // Steady stream of 80: outputs 10, out_valid two cycles after sample 9.
        got_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 80;
        tick();
        chk("latency_1", bus.out_valid, 0);
        tick();
        chk("latency_2", bus.out_valid, 1);
        chk("latency_data", bus.out_data, 10);
        repeat (10) tick();
        drain();
        chk("t2_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) if (i < got_q.size()) chk("t2_val", got_q[i], r2[i]);

        // Rounding of positive and negative sums.
        got_q.delete();
        for (int i = 0; i < 6; i++) send_kept(v3[i]);
        drain();
        chk("t3_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) if (i < got_q.size()) chk("t3_val", got_q[i], r3[i]);

        // Full FIFO with a push landing on the same edge as a pop.
        got_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_kept(8 * i);
        tick();
        tick();
        chk("full_valid", bus.out_valid, 1);
        align_kept();
        bus.in_valid = 1'b1;
        bus.in_data  = 40;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pushpop_overflow", bus.overflow, 0);
        chk("pushpop_head", bus.out_data, 2);
        drain();
        chk("t5_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) if (i < got_q.size()) chk("t5_val", got_q[i], r6[i]);

        // Overrun: fifth kept sample is dropped and overflow sticks.
        got_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_kept(8 * i);
        tick();
        tick();
        chk("ovf_set", bus.overflow, 1);
        drain();
        chk("ovf_sticky", bus.overflow, 1);
        chk("t4_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("t4_val", got_q[i], r5[i]);

        // Reset with three entries buffered.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send_kept(8 * i);
        tick();
        tick();
        chk("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_overflow", bus.overflow, 0);
        chk("mid_rst_primed", bus.primed, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            send(int'($urandom));
            chk("rewarm_no_valid", bus.out_valid, 0);
        end
        chk("rewarm_primed", bus.primed, 1);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = int'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ma_output_decimator.md
# ma_output_decimator

Downstream stage of the recursive moving-average filter. Takes the filter's running-sum stream, discards warm-up samples, scales it to a true average with round-half-up, and decimates by a fixed factor. Results are buffered in a small FIFO behind a valid/ready output so that a slower consumer (register bank, DMA, serializer) can stall without stalling the filter. The filter cannot be back-pressured, so FIFO overrun drops samples and raises a sticky flag.

## Interface
- `DATA_W`, 32: sample width; two's-complement signed on both input and output.
- `LOG2_WINDOW`, 3: log2 of the filter window, which is 2^LOG2_WINDOW. Sets the scaling shift and the warm-up length. Range 1..8.
- `DECIM`, 4: decimation factor, ≥1. A value of 1 keeps every post-warm-up sample.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  DATA_W  filter running sum.
- `in_valid`  in  1  `in_data` is valid this cycle. No ready is returned.
- `out_data`  out  DATA_W  scaled, decimated average; equals the FIFO head.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `primed`  out  1  warm-up complete.
- `overflow`  out  1  sticky; at least one kept sample was dropped. Cleared only by reset.

## Operation
- **Warm-up**
  - A counter counts `in_valid` cycles.
  - The first 2^LOG2_WINDOW valid samples after reset are discarded.
  - `primed` registers high on the edge that accepts the last discarded sample. The counter then saturates.
- **Decimation**
  - A phase counter runs 0..DECIM-1 and advances on every post-warm-up valid sample, wrapping to 0.
  - A sample is kept when phase==0, so the first post-warm-up sample is kept, then every DECIM-th sample after it.
- **Scaling**
  - s = (sign-extend(in_data) + 2^(LOG2_WINDOW-1)) >>> LOG2_WINDOW.
  - The add is done at DATA_W+1 bits and the shift is arithmetic, so the result always fits in DATA_W. No saturation is needed.
- **Pipeline**
  - Stage 1 registers s and a keep flag.
  - Stage 2 pushes into the FIFO when keep=1.
- **FIFO**
  - Push when keep=1 and (not full, or a pop occurs in the same cycle).
  - Pop when `out_valid && out_ready`.
  - A push while full with no simultaneous pop drops the new sample, sets `overflow`, and leaves the FIFO unchanged.
  - A push and pop in the same cycle at any occupancy leaves the count unchanged and never sets `overflow`.
  - A pop on empty is impossible, because `out_valid`=0.
- **Reset**
  - Clears warm-up counter, phase counter, stage-1 register, FIFO pointers and count, `primed`, and `overflow`.
  - Reset mid-stream discards all buffered data, and warm-up restarts.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `primed`=0, `overflow`=0.
- Latency: a kept sample presented at edge N appears at the FIFO head with `out_valid`=1 after edge N+2, provided the FIFO was empty.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` may be high every cycle. Throughput into the FIFO is at most 1 sample/cycle (DECIM=1), and output throughput is 1/cycle with `out_ready` held high.
- The full check uses occupancy at the stage-2 edge, including a same-edge pop.
- `overflow` rises the cycle after the dropped push.

## Structure
- Shared package `ma_pkg`: default `DATA_W`/`LOG2_WINDOW` constants shared with the filter, and a `ma_round_shift` function implementing the scaling rule.
- Sub-module `ma_sync_fifo`: generic synchronous FIFO with parameters DATA_W and DEPTH. Ports: push, pop, wdata, rdata, full, empty, count; read data taken from the head register/array.
- The top level holds the warm-up counter, phase counter, stage-1 register, and overflow logic.

## Test plan
1. Defaults; reset, then 8 valid samples of 80 → no `out_valid`; `primed` goes 0→1 after the 8th; `overflow`=0.
2. After warm-up, a continuous stream of 80 with `out_ready`=1 → output 10 for samples 9, 13, 17; `out_valid` first high 2 cycles after sample 9.
3. Rounding with DECIM=1, kept inputs 12, 11, 4, -12, -13, -4 → outputs 2, 1, 1, -1, -2, 0.
4. `out_ready`=0 with 5 kept samples 8, 16, 24, 32, 40 → the 5th is dropped, `overflow`=1; then `out_ready`=1 drains 1, 2, 3, 4 in order, then `out_valid`=0.
5. FIFO full, a push coinciding with a pop → no `overflow`; occupancy stays 4; order preserved.
6. `rst_n` low for one cycle with 3 entries buffered → `out_valid`=0 after that edge; the next 8 inputs are discarded again before any output.
